// File: rtl/pcs_40g_pkg.sv
// 40GBASE-R PCS shared definitions: alignment marker patterns, lane id type and
// AM bit layout, common to tx marker insertion and rx marker lock.
package pcs_40g_pkg;

    localparam int LANE_N_40G       = 4;
    localparam int LANE_ID_W_40G    = 2;
    localparam int GAP_N_DEFAULT    = 16383;
    localparam int AM_INV_N_DEFAULT = 4;

    localparam logic [1:0] AM_HEAD = 2'b01;

    // Payload layout: M0..M2 in bytes 0..2, BIP3 in byte 3, ~M0..~M2 in bytes 4..6, BIP7 in byte 7
    localparam int AM_M_LSB    = 0;
    localparam int AM_BIP3_LSB = 24;
    localparam int AM_INV_LSB  = 32;
    localparam int AM_BIP7_LSB = 56;

    typedef logic [LANE_ID_W_40G-1:0] lane_id_t;

    typedef enum logic [2:0] {
        FIND_1ST,
        COUNT_1,
        COMP_2ND,
        COUNT_2,
        COMP_AM
    } am_state_e;

    // Marker bytes as {M0, M1, M2}
    function automatic logic [23:0] am_pattern(input lane_id_t lane);
        case (lane)
            2'd0:    am_pattern = 24'h90_76_47;
            2'd1:    am_pattern = 24'hF0_C4_E6;
            2'd2:    am_pattern = 24'hC5_65_9B;
            default: am_pattern = 24'hA2_79_3D;
        endcase
    endfunction

    // Same bytes placed with M0 in the least significant byte, as they sit in data[23:0]
    function automatic logic [23:0] am_wire24(input lane_id_t lane);
        logic [23:0] p;
        p = am_pattern(lane);
        am_wire24 = {p[7:0], p[15:8], p[23:16]};
    endfunction

    function automatic logic [63:0] build_am(input lane_id_t lane, input logic [7:0] bip3,
                                             input logic [7:0] bip7);
        logic [23:0] w;
        w = am_wire24(lane);
        build_am = {bip7, ~w, bip3, w};
    endfunction

endpackage

// File: rtl/pcs_40g_rx_am_lock_am_match.sv
// Combinational alignment marker detector: compares one 66b block against every
// lane's marker pattern, ignoring the BIP bytes.
module pcs_40g_rx_am_lock_am_match
    import pcs_40g_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int HEAD_W    = 2,
    parameter int LANE_N    = 4,
    parameter int LANE_ID_W = 2
) (
    input  logic [HEAD_W-1:0]    head_i,
    input  logic [DATA_W-1:0]    data_i,
    output logic [LANE_N-1:0]    match_o,
    output logic [LANE_ID_W-1:0] id_o
);

    logic unused_bip;
    assign unused_bip = ^{data_i[AM_BIP3_LSB +: 8], data_i[AM_BIP7_LSB +: 8]};

    always_comb begin
        match_o = '0;
        id_o    = '0;
        for (int l = 0; l < LANE_N; l++) begin
            if (head_i == AM_HEAD &&
                data_i[AM_M_LSB +: 24] == am_wire24(lane_id_t'(l)) &&
                data_i[AM_INV_LSB +: 24] == ~am_wire24(lane_id_t'(l))) begin
                match_o[l] = 1'b1;
                id_o       = LANE_ID_W'(l);
            end
        end
    end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane alignment marker lock for the 40GBASE-R receive PCS: finds the marker,
// identifies the logical lane, and tracks the marker period.
module pcs_40g_rx_am_lock
    import pcs_40g_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int HEAD_W    = 2,
    parameter int LANE_N    = 4,
    parameter int LANE_ID_W = 2,
    parameter int GAP_N     = GAP_N_DEFAULT,
    parameter int AM_INV_N  = AM_INV_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 block_lock_i,
    input  logic                 valid_i,
    input  logic [HEAD_W-1:0]    head_i,
    input  logic [DATA_W-1:0]    data_i,
    output logic                 valid_o,
    output logic [HEAD_W-1:0]    head_o,
    output logic [DATA_W-1:0]    data_o,
    output logic                 am_v_o,
    output logic                 am_lock_o,
    output logic [LANE_ID_W-1:0] lane_id_o
);

    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam int INV_W = $clog2(AM_INV_N + 1);

    am_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [INV_W-1:0]      inv_q, inv_d, inv_inc;
    logic                  am_lock_q, am_lock_d;
    logic [LANE_ID_W-1:0]  lane_id_q, lane_id_d;
    logic                  am_v_q, am_v_d;
    logic                  valid_q, valid_d;
    logic [HEAD_W-1:0]     head_q, head_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic [LANE_N-1:0]     match_vec;
    logic [LANE_ID_W-1:0]  match_id;
    logic                  any_match, id_match;

    pcs_40g_rx_am_lock_am_match #(
        .DATA_W    (DATA_W),
        .HEAD_W    (HEAD_W),
        .LANE_N    (LANE_N),
        .LANE_ID_W (LANE_ID_W)
    ) u_am_match (
        .head_i  (head_i),
        .data_i  (data_i),
        .match_o (match_vec),
        .id_o    (match_id)
    );

    assign any_match = |match_vec;
    assign id_match  = match_vec[lane_id_q];
    assign cnt_inc   = cnt_q + 1'b1;
    assign inv_inc   = inv_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inv_d     = inv_q;
        am_lock_d = am_lock_q;
        lane_id_d = lane_id_q;
        am_v_d    = 1'b0;
        valid_d   = valid_i;
        head_d    = head_i;
        data_d    = data_i;

        if (!block_lock_i) begin
            state_d   = FIND_1ST;
            cnt_d     = '0;
            inv_d     = '0;
            am_lock_d = 1'b0;
        end else if (valid_i) begin
            case (state_q)
                FIND_1ST: begin
                    if (any_match) begin
                        lane_id_d = match_id;
                        cnt_d     = '0;
                        state_d   = COUNT_1;
                    end
                end
                COUNT_1, COUNT_2: begin
                    // Marker-like blocks inside the gap are plain data here
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(GAP_N)) begin
                        cnt_d   = '0;
                        state_d = (state_q == COUNT_1) ? COMP_2ND : COMP_AM;
                    end
                end
                COMP_2ND: begin
                    if (id_match) begin
                        am_lock_d = 1'b1;
                        am_v_d    = 1'b1;
                        inv_d     = '0;
                        state_d   = COUNT_2;
                    end else begin
                        state_d = FIND_1ST;
                    end
                end
                COMP_AM: begin
                    if (id_match) begin
                        am_v_d  = 1'b1;
                        inv_d   = '0;
                        state_d = COUNT_2;
                    end else if (inv_inc == INV_W'(AM_INV_N)) begin
                        inv_d     = '0;
                        am_lock_d = 1'b0;
                        state_d   = FIND_1ST;
                    end else begin
                        inv_d   = inv_inc;
                        state_d = COUNT_2;
                    end
                end
                default: state_d = FIND_1ST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FIND_1ST;
            cnt_q     <= '0;
            inv_q     <= '0;
            am_lock_q <= 1'b0;
            lane_id_q <= '0;
            am_v_q    <= 1'b0;
            valid_q   <= 1'b0;
            head_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_q     <= inv_d;
            am_lock_q <= am_lock_d;
            lane_id_q <= lane_id_d;
            am_v_q    <= am_v_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            data_q    <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign head_o    = head_q;
    assign data_o    = data_q;
    assign am_v_o    = am_v_q;
    assign am_lock_o = am_lock_q;
    assign lane_id_o = lane_id_q;

endmodule
